// File: rtl/led_mode_ctrl.sv
// led_mode_ctrl: debounced on/off push buttons drive an OFF/ON/BLINK mode FSM and an active-low LED
// clk        : system clock, all state on the rising edge
// rst_n      : asynchronous active-low reset
// button_on  : raw "on" button, active-low, asynchronous to clk
// button_off : raw "off" button, active-low, asynchronous to clk
// led        : registered LED drive, active-low (0 = lit)
// mode       : current state, 00 = OFF, 01 = ON, 10 = BLINK
module led_mode_ctrl #(
  parameter int DEBOUNCE_CYCLES   = 500000,
  parameter int BLINK_HALF_PERIOD = 12500000,
  parameter int CNT_W             = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       button_on,
  input  logic       button_off,
  output logic       led,
  output logic [1:0] mode
);
  typedef enum logic [1:0] {S_OFF = 2'b00, S_ON = 2'b01, S_BLINK = 2'b10} state_t;
  localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_HALF_PERIOD - 1);
  // bit 0 = "on" button, bit 1 = "off" button
  logic [1:0]       w_raw;
  logic [1:0]       r_meta, r_sync, r_stable, r_stable_d, r_press;
  logic [CNT_W-1:0] r_deb_cnt [2];
  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_blink_cnt, w_blink_cnt_n;
  logic             r_lit, w_lit_n, r_led, w_led_n;
  assign w_raw = {button_off, button_on};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_meta     <= '1;
      r_sync     <= '1;
      r_stable   <= '1;
      r_stable_d <= '1;
      r_press    <= '0;
      for (int i = 0; i < 2; i++) r_deb_cnt[i] <= '0;
    end else begin
      r_meta     <= w_raw;
      r_sync     <= r_meta;
      r_stable_d <= r_stable;
      // one-cycle pulse the edge after the debounced level falls
      r_press    <= r_stable_d & ~r_stable;
      for (int i = 0; i < 2; i++)
        if (r_sync[i] == r_stable[i]) r_deb_cnt[i] <= '0;
        else if (r_deb_cnt[i] == DEB_LAST) begin
          r_stable[i]  <= r_sync[i];
          r_deb_cnt[i] <= '0;
        end else r_deb_cnt[i] <= r_deb_cnt[i] + 1'b1;
    end
  // off beats on; a held off button masks on presses
  always_comb begin
    w_next = r_state;
    if (r_press[1]) w_next = S_OFF;
    else if (r_press[0] && r_stable[1]) w_next = (r_state == S_ON) ? S_BLINK : S_ON;
  end
  // blink timer restarts lit on entry and stays idle outside BLINK
  always_comb begin
    w_blink_cnt_n = '0;
    w_lit_n       = 1'b1;
    if (w_next == S_BLINK && r_state == S_BLINK) begin
      w_blink_cnt_n = (r_blink_cnt == BLINK_LAST) ? '0 : r_blink_cnt + 1'b1;
      w_lit_n       = (r_blink_cnt == BLINK_LAST) ? ~r_lit : r_lit;
    end
    w_led_n = ~((w_next == S_ON) || (w_next == S_BLINK && w_lit_n));
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state     <= S_OFF;
      r_blink_cnt <= '0;
      r_lit       <= 1'b1;
      r_led       <= 1'b1;
    end else begin
      r_state     <= w_next;
      r_blink_cnt <= w_blink_cnt_n;
      r_lit       <= w_lit_n;
      r_led       <= w_led_n;
    end
  assign led  = r_led;
  assign mode = r_state;
endmodule

// File: tb/tb_led_mode_ctrl.sv
// tb_led_mode_ctrl: directed stimulus with a cycle model and literal checks for led_mode_ctrl
module tb_led_mode_ctrl;
  localparam int DEB  = 4;
  localparam int HALF = 3;
  logic       clk = 1'b0, rst_n = 1'b1, button_on = 1'b1, button_off = 1'b1;
  logic       led;
  logic [1:0] mode;
  int n_pass = 0, n_total = 0;
  // model: accepted levels, sync pipeline, level run lengths, pending press events, mode, time in BLINK
  bit m_valid = 1'b0;
  int m_mode, m_old, m_t;
  bit m_acc [2], m_s1 [2], m_s2 [2], m_prev [2], m_fell [2], m_press [2];
  int m_age [2];

  led_mode_ctrl #(.DEBOUNCE_CYCLES(DEB), .BLINK_HALF_PERIOD(HALF), .CNT_W(24)) dut (
    .clk(clk), .rst_n(rst_n), .button_on(button_on), .button_off(button_off),
    .led(led), .mode(mode)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_on_hold();
    button_on = 1'b0;
    wait_n(10);
    button_on = 1'b1;
    wait_n(10);
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_valid = 1'b1;
      m_mode  = 0;
      m_t     = 0;
      for (int b = 0; b < 2; b++) begin
        m_acc[b] = 1'b1; m_s1[b] = 1'b1; m_s2[b] = 1'b1; m_prev[b] = 1'b1;
        m_age[b] = 0; m_fell[b] = 1'b0; m_press[b] = 1'b0;
      end
    end else if (m_valid) begin
      m_old = m_mode;
      if (m_press[1]) m_mode = 0;
      else if (m_press[0] && m_acc[1]) m_mode = (m_mode == 1) ? 2 : 1;
      m_t = (m_mode == 2 && m_old == 2) ? m_t + 1 : 0;
      for (int b = 0; b < 2; b++) begin
        m_press[b] = m_fell[b];
        m_fell[b]  = 1'b0;
        m_age[b]   = (m_s2[b] == m_prev[b]) ? m_age[b] + 1 : 1;
        m_prev[b]  = m_s2[b];
        if (m_s2[b] != m_acc[b] && m_age[b] >= DEB) begin
          m_fell[b] = !m_s2[b];
          m_acc[b]  = m_s2[b];
        end
        m_s2[b] = m_s1[b];
      end
      m_s1[0] = button_on;
      m_s1[1] = button_off;
    end
  end

  always @(negedge clk)
    if (m_valid) begin
      check("model_mode", mode, 2'(m_mode));
      check("model_led", {1'b0, led},
            m_mode == 1 ? 2'd0 : m_mode == 2 ? 2'((m_t / HALF) % 2) : 2'd1);
    end

  initial begin
    #2 rst_n = 1'b0;
    #1;
    check("reset_async_mode", mode, 2'b00);
    check("reset_async_led", {1'b0, led}, 2'b01);
    @(negedge clk);
    rst_n = 1'b1;
    wait_n(3);
    repeat (5) begin
      button_on = 1'b0;
      wait_n(3);
      button_on = 1'b1;
      wait_n(3);
    end
    wait_n(6);
    check("bounce_mode", mode, 2'b00);
    check("bounce_led", {1'b0, led}, 2'b01);
    button_on = 1'b0;
    wait_n(7);
    check("latency_e6_mode", mode, 2'b00);
    wait_n(1);
    check("latency_e7_mode", mode, 2'b01);
    check("latency_e7_led", {1'b0, led}, 2'b00);
    wait_n(3);
    button_on = 1'b1;
    wait_n(10);
    button_on = 1'b0;
    wait_n(8);
    for (int i = 0; i < 12; i++) begin
      check("blink_mode", mode, 2'b10);
      check("blink_led", {1'b0, led}, 2'((i / 3) % 2));
      if (i == 3) button_on = 1'b1;
      wait_n(1);
    end
    wait_n(10);
    press_on_hold();
    check("third_press_mode", mode, 2'b01);
    check("third_press_led", {1'b0, led}, 2'b00);
    button_on  = 1'b0;
    button_off = 1'b0;
    wait_n(7);
    check("both_e6_mode", mode, 2'b01);
    wait_n(1);
    check("both_e7_mode", mode, 2'b00);
    check("both_e7_led", {1'b0, led}, 2'b01);
    button_on = 1'b1;
    wait_n(10);
    button_on = 1'b0;
    wait_n(12);
    check("off_held_mode", mode, 2'b00);
    button_on = 1'b1;
    wait_n(10);
    button_off = 1'b1;
    wait_n(10);
    check("off_release_mode", mode, 2'b00);
    press_on_hold();
    button_on = 1'b0;
    wait_n(8);
    check("reentry_mode", mode, 2'b10);
    check("reentry_led", {1'b0, led}, 2'b00);
    wait_n(2);
    #2 rst_n = 1'b0;
    #1;
    check("reset_blink_mode", mode, 2'b00);
    check("reset_blink_led", {1'b0, led}, 2'b01);
    @(negedge clk);
    rst_n = 1'b1;
    wait_n(7);
    check("post_reset_e6_mode", mode, 2'b00);
    wait_n(1);
    check("post_reset_e7_mode", mode, 2'b01);
    check("post_reset_e7_led", {1'b0, led}, 2'b00);
    button_on = 1'b1;
    wait_n(10);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
